reg_file_param: RTL and testbench

- Parametrised successor to the processor's 16-bit, 256-entry, two-read/one-write register file.
- Width and depth are configurable.
- After reset, a hardware clear sequencer initialises every entry. Software no longer depends on reset-time preloads.
- A per-entry pending scoreboard marks registers whose write is outstanding, for hazard detection in the datapath.

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_clear_seq.sv | 56 +++++
 rtl/reg_file_param.sv | 112 +++++++++++
 tb/tb_reg_file_param.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types for the parametrised register file.
// Optional forwarding path is enabled by defining REGFILE_BYPASS_EN.
package reg_file_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then parks in READY.
// Used by reg_file_param (REGFILE_BYPASS_EN has no effect here).
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              in_clk,
  input  logic              in_rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_add
);

  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign clr_we  = (state_q == ST_CLEAR);
  assign clr_add = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/reg_file_param.sv
// Two-read/one-write register file with hardware clear and pending scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [ADDR_W-1:0] in_read_reg_1_add,
  input  logic [ADDR_W-1:0] in_read_reg_2_add,
  input  logic [ADDR_W-1:0] in_write_reg_add,
  input  logic [DATA_W-1:0] in_write_reg_val,
  input  logic              in_write_en,
  input  logic              in_lock_en,
  input  logic [ADDR_W-1:0] in_lock_add,
  output logic [DATA_W-1:0] out_reg_1_val,
  output logic [DATA_W-1:0] out_reg_2_val,
  output logic              out_reg_1_pend,
  output logic              out_reg_2_pend,
  output logic              out_busy,
  output logic              out_write_ack
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_add;

  reg_file_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_add (clr_add)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              ack_q, ack_d;

  logic              wr_go, lk_go;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign wr_go = ~busy & in_write_en;
  assign lk_go = ~busy & in_lock_en;

  always_comb begin
    mem_we = clr_we | wr_go;
    mem_wa = clr_we ? clr_add : in_write_reg_add;
    mem_wd = clr_we ? INIT_VAL : in_write_reg_val;
  end

  // Storage has no reset; the sequencer owns initialisation.
  always_ff @(posedge in_clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_comb begin
    pend_d = pend_q;
    ack_d  = wr_go;
    if (wr_go) pend_d[in_write_reg_add] = 1'b0;
    if (lk_go) pend_d[in_lock_add] = 1'b1;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      pend_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ack_q  <= ack_d;
    end
  end

  logic [ADDR_W-1:0] rd_add  [2];
  logic [DATA_W-1:0] rd_val  [2];
  logic              rd_pend [2];

  assign rd_add[0] = in_read_reg_1_add;
  assign rd_add[1] = in_read_reg_2_add;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p]  = mem_q[rd_add[p]];
      rd_pend[p] = pend_q[rd_add[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_go && (rd_add[p] == in_write_reg_add)) begin
        rd_val[p]  = in_write_reg_val;
        rd_pend[p] = lk_go && (in_lock_add == rd_add[p]);
      end
`endif
      if (busy) begin
        rd_val[p]  = INIT_VAL;
        rd_pend[p] = 1'b0;
      end
    end
  end

  assign out_reg_1_val  = rd_val[0];
  assign out_reg_2_val  = rd_val[1];
  assign out_reg_1_pend = rd_pend[0];
  assign out_reg_2_pend = rd_pend[1];
  assign out_busy       = busy;
  assign out_write_ack  = ack_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed steps plus random traffic vs. a model.
// Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_reg_file_param;

  localparam int          DW    = 16;
  localparam int          AW    = 8;
  localparam int          DEPTH = 256;
  localparam logic [15:0] INIT  = 16'h0000;

  logic          in_clk = 1'b0;
  logic          in_rst = 1'b1;
  logic [AW-1:0] in_read_reg_1_add = '0;
  logic [AW-1:0] in_read_reg_2_add = '0;
  logic [AW-1:0] in_write_reg_add = '0;
  logic [DW-1:0] in_write_reg_val = '0;
  logic          in_write_en = 1'b0;
  logic          in_lock_en = 1'b0;
  logic [AW-1:0] in_lock_add = '0;
  logic [DW-1:0] out_reg_1_val, out_reg_2_val;
  logic          out_reg_1_pend, out_reg_2_pend;
  logic          out_busy, out_write_ack;

  always #5 in_clk = ~in_clk;

  reg_file_param dut (
    .in_clk            (in_clk),
    .in_rst            (in_rst),
    .in_read_reg_1_add (in_read_reg_1_add),
    .in_read_reg_2_add (in_read_reg_2_add),
    .in_write_reg_add  (in_write_reg_add),
    .in_write_reg_val  (in_write_reg_val),
    .in_write_en       (in_write_en),
    .in_lock_en        (in_lock_en),
    .in_lock_add       (in_lock_add),
    .out_reg_1_val     (out_reg_1_val),
    .out_reg_2_val     (out_reg_2_val),
    .out_reg_1_pend    (out_reg_1_pend),
    .out_reg_2_pend    (out_reg_2_pend),
    .out_busy          (out_busy),
    .out_write_ack     (out_write_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_mem  [DEPTH];
  bit          m_pend [DEPTH];
  int          clr_edges;
  bit          ack_exp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_val(input logic [7:0] ra);
    if (clr_edges < DEPTH) return INIT;
`ifdef REGFILE_BYPASS_EN
    if (in_write_en && ra == in_write_reg_add) return in_write_reg_val;
`endif
    return m_mem[ra];
  endfunction

  function automatic bit exp_pend(input logic [7:0] ra);
    if (clr_edges < DEPTH) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (in_write_en && ra == in_write_reg_add)
      return in_lock_en && in_lock_add == ra;
`endif
    return m_pend[ra];
  endfunction

  task automatic cyc(input bit we, input logic [7:0] wa,
                     input logic [15:0] wd, input bit le,
                     input logic [7:0] la, input logic [7:0] r1,
                     input logic [7:0] r2);
    in_write_en       = we;
    in_write_reg_add  = wa;
    in_write_reg_val  = wd;
    in_lock_en        = le;
    in_lock_add       = la;
    in_read_reg_1_add = r1;
    in_read_reg_2_add = r2;
    @(negedge in_clk);
    chk("busy", 32'(out_busy), 32'(clr_edges < DEPTH));
    chk("ack", 32'(out_write_ack), 32'(ack_exp));
    chk("r1_val", 32'(out_reg_1_val), 32'(exp_val(r1)));
    chk("r2_val", 32'(out_reg_2_val), 32'(exp_val(r2)));
    chk("r1_pend", 32'(out_reg_1_pend), 32'(exp_pend(r1)));
    chk("r2_pend", 32'(out_reg_2_pend), 32'(exp_pend(r2)));
    @(posedge in_clk);
    if (clr_edges < DEPTH) begin
      m_mem[clr_edges] = INIT;
      clr_edges++;
      ack_exp = 1'b0;
    end else begin
      if (we) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (le) m_pend[la] = 1'b1;
      ack_exp = we;
    end
    #1;
  endtask

  task automatic rnd_cyc(input bit allow_wr);
    cyc(allow_wr & 1'($urandom_range(0, 1)),
        8'($urandom_range(0, 15)), 16'($urandom),
        allow_wr & 1'($urandom_range(0, 2) == 0),
        8'($urandom_range(0, 15)),
        8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    in_write_en = 1'b0;
    in_lock_en  = 1'b0;
    in_rst      = 1'b0;
    #1;
    chk("rst_busy", 32'(out_busy), 32'd1);
    chk("rst_ack", 32'(out_write_ack), 32'd0);
    chk("rst_pend1", 32'(out_reg_1_pend), 32'd0);
    chk("rst_pend2", 32'(out_reg_2_pend), 32'd0);
    @(posedge in_clk);
    #1;
    in_rst    = 1'b1;
    clr_edges = 0;
    ack_exp   = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 'x;
  endtask

  initial begin
    #1;
    do_reset();
    // writes and locks attempted throughout the clear must be dropped
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 8'd5, 16'hBEEF, 1'b1, 8'd6, 8'd5, 8'd6);
    cyc(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 8'd0, 8'd128);
    cyc(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 8'd255, 8'd5);
    cyc(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 8'd6, 8'd6);

    cyc(1'b1, 8'd3, 16'h1234, 1'b0, 8'd0, 8'd3, 8'd3);
    cyc(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 8'd3, 8'd3);

    cyc(1'b0, 8'd0, 16'h0, 1'b1, 8'd7, 8'd7, 8'd7);
    cyc(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 8'd7, 8'd7);
    cyc(1'b1, 8'd7, 16'h00AA, 1'b0, 8'd0, 8'd7, 8'd7);
    cyc(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 8'd7, 8'd7);
    cyc(1'b1, 8'd7, 16'h00BB, 1'b1, 8'd7, 8'd7, 8'd7);
    cyc(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 8'd7, 8'd7);

    cyc(1'b1, 8'd9, 16'h5A5A, 1'b0, 8'd0, 8'd9, 8'd9);
    cyc(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 8'd9, 8'd9);

    repeat (400) rnd_cyc(1'b1);

    // reset during normal operation, then again part-way into the clear
    do_reset();
    repeat (100) rnd_cyc(1'b1);
    do_reset();
    repeat (DEPTH) rnd_cyc(1'b1);
    repeat (32) rnd_cyc(1'b0);
    repeat (200) rnd_cyc(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
